uart_axil_regs: RTL and testbench

AXI4-Lite subordinate (responder) register block for the UART. It terminates the bus driven by the system's AXI4-Lite manager and exposes UART control and status as four 32-bit registers. It feeds the transmitter through a one-byte holding register with a valid/ready handshake, and captures received bytes from the receiver. Sits between the AXI4-Lite interconnect and the UART TX/RX/baud-generator cores.

---
 rtl/uart_axil_regs.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_axil_regs.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axil_regs.sv
// AXI4-Lite register block for the UART: TXDATA, RXDATA, STATUS and BAUD_DIV.
// Feeds the transmitter through a one-byte holding slot and captures received
// bytes into a one-byte buffer with a sticky overrun flag.
module uart_axil_regs #(
    parameter int          ALEN       = 32,
    parameter int          DLEN       = 32,
    parameter logic [15:0] BAUD_RESET = 16'd868
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ALEN-1:0]   awaddr,
    input  logic [2:0]        awprot,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DLEN-1:0]   wdata,
    input  logic [DLEN/8-1:0] wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ALEN-1:0]   araddr,
    input  logic [2:0]        arprot,
    output logic              rvalid,
    input  logic              rready,
    output logic [DLEN-1:0]   rdata,
    output logic [1:0]        rresp,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [15:0]       baud_div
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ALEN-1:0]   awaddr_q, awaddr_d;
    logic [DLEN-1:0]   wdata_q, wdata_d;
    logic [DLEN/8-1:0] wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DLEN-1:0]   rdata_q, rdata_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d, rx_byte_q, rx_byte_d;
    logic [15:0]       baud_q, baud_d;
    logic              rx_full_q, rx_full_d, ovr_q, ovr_d;

    logic              aw_hs, w_hs, ar_hs, wr_go, wr_dec, rd_dec, rx_pop;
    logic              tx_take, tx_busy, ovr_clr;
    logic [ALEN-1:0]   wr_addr;
    logic [DLEN-1:0]   wr_data;
    logic [DLEN/8-1:0] wr_strb;
    logic [1:0]        wr_sel, rd_sel;
    logic              unused_ok;

    // Readies are forced low during reset so no handshake can land in it.
    assign awready = !areset && !aw_held_q && !bvalid_q;
    assign wready  = !areset && !w_held_q && !bvalid_q;
    assign arready = !areset && !rvalid_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // A beat arriving this cycle bypasses its holding register, so the write
    // executes in the same cycle as the later of the two handshakes.
    assign wr_addr = aw_held_q ? awaddr_q : awaddr;
    assign wr_data = w_held_q ? wdata_q : wdata;
    assign wr_strb = w_held_q ? wstrb_q : wstrb;
    assign wr_go   = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_dec  = |wr_addr[ALEN-1:4];
    assign wr_sel  = wr_addr[3:2];

    assign rd_dec  = |araddr[ALEN-1:4];
    assign rd_sel  = araddr[3:2];
    assign rx_pop  = ar_hs && !rd_dec && (rd_sel == 2'd1);

    assign tx_take = tx_valid_q && tx_ready;
    assign tx_busy = tx_valid_q && !tx_ready;

    assign unused_ok = &{1'b0, awprot, arprot, wr_addr[1:0], araddr[1:0],
                         wr_data[DLEN-1:16], wr_strb[DLEN/8-1:2]};

    // Write channel: latch AW/W beats, execute the write, hold the response.
    always_comb begin
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        tx_valid_d = tx_valid_q && !tx_take;
        tx_data_d  = tx_data_q;
        baud_d     = baud_q;
        ovr_clr    = 1'b0;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end
        if (bvalid_q && bready)
            bvalid_d = 1'b0;
        if (wr_go) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_OKAY;
            if (wr_dec) begin
                bresp_d = RESP_DECERR;
            end else begin
                case (wr_sel)
                    2'd0: if (wr_strb[0]) begin
                        // A slot freed by tx_ready this cycle can be refilled.
                        if (tx_busy) begin
                            bresp_d = RESP_SLVERR;
                        end else begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = wr_data[7:0];
                        end
                    end
                    2'd2: ovr_clr = wr_strb[0] && wr_data[2];
                    2'd3: begin
                        if (wr_strb[0]) baud_d[7:0]  = wr_data[7:0];
                        if (wr_strb[1]) baud_d[15:8] = wr_data[15:8];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read channel: register data/response on AR handshake, hold until rready.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && rready)
            rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = '0;
            if (rd_dec) begin
                rresp_d = RESP_DECERR;
            end else begin
                case (rd_sel)
                    2'd1: begin
                        rdata_d[DLEN-1] = rx_full_q;
                        rdata_d[7:0]    = rx_byte_q;
                    end
                    2'd2: rdata_d[2:0]  = {ovr_q, rx_full_q, tx_valid_q};
                    2'd3: rdata_d[15:0] = baud_q;
                    default: ;
                endcase
            end
        end
    end

    // RX buffer: a pop frees the slot for a byte arriving the same cycle;
    // an overrun set beats a same-cycle W1C clear.
    always_comb begin
        rx_full_d = rx_full_q && !rx_pop;
        rx_byte_d = rx_byte_q;
        ovr_d     = ovr_q && !ovr_clr;
        if (rx_valid) begin
            if (!rx_full_d) begin
                rx_byte_d = rx_data;
                rx_full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset discarding anything in flight.
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            baud_q     <= BAUD_RESET;
            rx_full_q  <= 1'b0;
            rx_byte_q  <= '0;
            ovr_q      <= 1'b0;
        end else begin
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            baud_q     <= baud_d;
            rx_full_q  <= rx_full_d;
            rx_byte_q  <= rx_byte_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign baud_div = baud_q;

endmodule

// File: tb/tb_uart_axil_regs.sv
// Bench for uart_axil_regs: directed scenarios with literal expectations,
// then randomized bus/UART traffic compared every cycle to a queue-based model.
module tb_uart_axil_regs;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [3:0]  wstrb = '0;
    logic        tx_ready = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        awready, wready, bvalid, arready, rvalid, tx_valid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic [15:0] baud_div;

    uart_axil_regs dut (
        .aclk(aclk), .areset(areset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .baud_div(baud_div)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for handshake at %0t", nm, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [31:0] d; logic [3:0] s; } wbeat_t;
    logic [31:0] awq[$];
    wbeat_t      wq[$];
    logic        m_bv, m_rv, m_txv, m_rxf, m_ovr;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;
    logic [7:0]  m_txd, m_rxb;
    logic [15:0] m_baud;

    task automatic model_step();
        logic awr, wr, arr, pop, tx_free, ovr_set;
        logic [31:0] a;
        wbeat_t b;
        if (areset) begin
            m_bv = 0; m_bresp = 0; m_rv = 0; m_rdata = 0; m_rresp = 0;
            m_txv = 0; m_txd = 0; m_baud = 16'h0364;
            m_rxf = 0; m_rxb = 0; m_ovr = 0;
            awq.delete(); wq.delete();
            return;
        end
        awr = (awq.size() == 0) && !m_bv;
        wr  = (wq.size() == 0) && !m_bv;
        arr = !m_rv;
        pop = 0;
        // reads see the register values from before this edge
        if (m_rv && rready) m_rv = 0;
        if (arvalid && arr) begin
            m_rv = 1; m_rresp = 0; m_rdata = 0;
            if (araddr[31:4] != 0) m_rresp = 2'b11;
            else case (araddr[3:2])
                2'd1: begin m_rdata = (32'(m_rxf) << 31) | 32'(m_rxb); pop = 1; end
                2'd2: m_rdata = 32'(m_txv) | (32'(m_rxf) << 1) | (32'(m_ovr) << 2);
                2'd3: m_rdata = 32'(m_baud);
                default: ;
            endcase
        end
        if (m_bv && bready) m_bv = 0;
        if (awvalid && awr) awq.push_back(awaddr);
        if (wvalid && wr) wq.push_back('{wdata, wstrb});
        tx_free = !m_txv || tx_ready;
        if (tx_ready) m_txv = 0;
        if (pop) m_rxf = 0;
        ovr_set = 0;
        if (rx_valid) begin
            if (m_rxf) ovr_set = 1;
            else begin m_rxb = rx_data; m_rxf = 1; end
        end
        if (awq.size() > 0 && wq.size() > 0) begin
            a = awq.pop_front();
            b = wq.pop_front();
            m_bv = 1; m_bresp = 0;
            if (a[31:4] != 0) m_bresp = 2'b11;
            else case (a[3:2])
                2'd0: if (b.s[0]) begin
                    if (tx_free) begin m_txv = 1; m_txd = b.d[7:0]; end
                    else m_bresp = 2'b10;
                end
                2'd2: if (b.s[0] && b.d[2]) m_ovr = 0;
                2'd3: begin
                    if (b.s[0]) m_baud[7:0]  = b.d[7:0];
                    if (b.s[1]) m_baud[15:8] = b.d[15:8];
                end
                default: ;
            endcase
        end
        if (ovr_set) m_ovr = 1;
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
        model_step();
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge aclk);
        if (chk_en) begin
            chk("awready", awready, !areset && awq.size() == 0 && !m_bv);
            chk("wready", wready, !areset && wq.size() == 0 && !m_bv);
            chk("arready", arready, !areset && !m_rv);
            chk("bvalid", bvalid, m_bv);
            if (m_bv) chk("bresp", bresp, m_bresp);
            chk("rvalid", rvalid, m_rv);
            if (m_rv) begin
                chk("rdata", rdata, m_rdata);
                chk("rresp", rresp, m_rresp);
            end
            chk("tx_valid", tx_valid, m_txv);
            chk("tx_data", tx_data, m_txd);
            chk("baud_div", baud_div, m_baud);
        end
    end

    // ---------------- directed transaction tasks ----------------
    task automatic axw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int aw_dly, input int w_dly,
                       output logic [1:0] resp, output int lat);
        bit awd, wd, got;
        int n, hs_cyc;
        awd = 0; wd = 0; got = 0; n = 0; hs_cyc = 0; resp = 2'bxx; lat = -1;
        while (!(awd && wd) && n < 40) begin
            awvalid = !awd && (n >= aw_dly); awaddr = a;
            wvalid  = !wd && (n >= w_dly);   wdata = d; wstrb = s;
            @(negedge aclk);
            if (awvalid && awready) begin awd = 1; hs_cyc = cyc; end
            if (wvalid && wready) begin wd = 1; hs_cyc = cyc; end
            @(posedge aclk); #1;
            n++;
        end
        awvalid = 0; wvalid = 0;
        if (!(awd && wd)) begin tmo("aw_w_hs"); return; end
        bready = 1; n = 0;
        while (!got && n < 40) begin
            @(negedge aclk);
            if (bvalid) begin resp = bresp; lat = cyc - hs_cyc; got = 1; end
            @(posedge aclk); #1;
            n++;
        end
        bready = 0;
        if (!got) tmo("bvalid");
    endtask

    task automatic axr(input logic [31:0] a, input bit rxp, input logic [7:0] rxb,
                       output logic [31:0] d, output logic [1:0] resp, output int lat);
        bit done, got;
        int n, hs_cyc;
        done = 0; got = 0; n = 0; hs_cyc = 0; d = 'x; resp = 2'bxx; lat = -1;
        arvalid = 1; araddr = a; rx_valid = rxp; rx_data = rxb;
        while (!done && n < 40) begin
            @(negedge aclk);
            if (arready) begin done = 1; hs_cyc = cyc; end
            @(posedge aclk); #1;
            rx_valid = 0;
            n++;
        end
        arvalid = 0;
        if (!done) begin tmo("ar_hs"); return; end
        rready = 1; n = 0;
        while (!got && n < 40) begin
            @(negedge aclk);
            if (rvalid) begin d = rdata; resp = rresp; lat = cyc - hs_cyc; got = 1; end
            @(posedge aclk); #1;
            n++;
        end
        rready = 0;
        if (!got) tmo("rvalid");
    endtask

    function automatic logic [31:0] rnd_addr();
        int k;
        k = int'($urandom % 10);
        if (k == 9) return 32'h20 | (32'($urandom % 4) << 2);
        return 32'(k % 4) << 2;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          l;
        bit          awh, wh, arh;

        // reset
        @(posedge aclk); #1;
        chk_en = 1;
        repeat (2) @(posedge aclk);
        #1 areset = 0;

        // baud reset value readback
        axr(32'hC, 0, 8'h00, d, r, l);
        chk("rst_baud_rdata", d, 32'h0000_0364);
        chk("rst_baud_rresp", r, 2'b00);
        chk("rd_latency", l, 1);

        // W leads AW by three cycles, low byte only
        axw(32'hC, 32'h0000_01B2, 4'b0001, 3, 0, r, l);
        chk("baud_bresp", r, 2'b00);
        chk("wr_latency", l, 1);
        chk("baud_val", baud_div, 16'h03B2);

        // TX holding slot with a stalled transmitter
        axw(32'h0, 32'h41, 4'b0001, 0, 0, r, l);
        chk("tx1_bresp", r, 2'b00);
        chk("tx1_valid", tx_valid, 1'b1);
        chk("tx1_data", tx_data, 8'h41);
        axw(32'h0, 32'h42, 4'b0001, 0, 0, r, l);
        chk("tx2_bresp", r, 2'b10);
        chk("tx2_data", tx_data, 8'h41);
        tx_ready = 1;
        @(posedge aclk); #1;
        tx_ready = 0;
        chk("tx_drop", tx_valid, 1'b0);

        // RX overrun and W1C clear
        rx_valid = 1; rx_data = 8'h55;
        @(posedge aclk); #1;
        rx_data = 8'h66;
        @(posedge aclk); #1;
        rx_valid = 0;
        axr(32'h8, 0, 8'h00, d, r, l);
        chk("status_ovr", d, 32'h6);
        axr(32'h4, 0, 8'h00, d, r, l);
        chk("rx_first", d, 32'h8000_0055);
        axr(32'h8, 0, 8'h00, d, r, l);
        chk("status_popped", d, 32'h4);
        axw(32'h8, 32'h4, 4'b0001, 0, 0, r, l);
        chk("w1c_bresp", r, 2'b00);
        axr(32'h8, 0, 8'h00, d, r, l);
        chk("status_clear", d, 32'h0);

        // byte arriving in the same cycle as the pop
        rx_valid = 1; rx_data = 8'h10;
        @(posedge aclk); #1;
        rx_valid = 0;
        axr(32'h4, 1, 8'h77, d, r, l);
        chk("rx_pop_old", d, 32'h8000_0010);
        axr(32'h4, 0, 8'h00, d, r, l);
        chk("rx_pop_new", d, 32'h8000_0077);
        axr(32'h8, 0, 8'h00, d, r, l);
        chk("rx_no_ovr", d, 32'h0);

        // decode error
        axw(32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, r, l);
        chk("dec_bresp", r, 2'b11);
        chk("dec_baud", baud_div, 16'h03B2);
        axr(32'h20, 0, 8'h00, d, r, l);
        chk("dec_rresp", r, 2'b11);
        chk("dec_rdata", d, 32'h0);

        // response held under back-pressure, then discarded by reset
        awvalid = 1; awaddr = 32'hC; wvalid = 1; wdata = 32'h1234; wstrb = 4'b0011;
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("hold_bvalid", bvalid, 1'b1);
            chk("hold_bresp", bresp, 2'b00);
            chk("hold_awready", awready, 1'b0);
            @(posedge aclk); #1;
        end
        chk("hold_baud", baud_div, 16'h1234);
        areset = 1;
        @(posedge aclk); #1;
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_baud", baud_div, 16'h0364);
        areset = 0;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge aclk);
            awh = awvalid && awready;
            wh  = wvalid && wready;
            arh = arvalid && arready;
            @(posedge aclk); #1;
            if (!awvalid || awh) begin
                awvalid = ($urandom % 3) != 0; awaddr = rnd_addr(); awprot = 3'($urandom);
            end
            if (!wvalid || wh) begin
                wvalid = ($urandom % 3) != 0; wdata = $urandom; wstrb = 4'($urandom);
            end
            if (!arvalid || arh) begin
                arvalid = ($urandom % 3) != 0; araddr = rnd_addr(); arprot = 3'($urandom);
            end
            bready   = ($urandom % 4) != 0;
            rready   = ($urandom % 4) != 0;
            tx_ready = ($urandom % 3) == 0;
            rx_valid = ($urandom % 4) == 0;
            rx_data  = 8'($urandom);
            areset   = ($urandom % 500) == 0;
        end
        awvalid = 0; wvalid = 0; arvalid = 0; rx_valid = 0; areset = 0;
        bready = 1; rready = 1;
        repeat (5) @(posedge aclk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
